// File: rtl/demux_1_2_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_2_stream
// Description : 1:2 stream demultiplexer. Each tagged input word is steered to
//               output A (in_sel=0) or B (in_sel=1). Each output has its own
//               first-word-fall-through FIFO with valid/ready handshaking.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_2_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [LW-1:0]    a_level,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [LW-1:0]    b_level
);

  localparam int            PW     = $clog2(DEPTH);
  localparam logic [LW-1:0] c_full = LW'(DEPTH);

  logic [1:0]       w_out_ready;
  logic [WIDTH-1:0] w_head  [2];
  logic [LW-1:0]    w_level [2];
  logic             w_accept;

  assign w_out_ready = {b_ready, a_ready};

  // Readiness depends only on the tag and registered occupancy, never on the
  // consumer readys, so a full FIFO blocks its words even while it pops.
  assign in_ready = in_sel ? (w_level[1] != c_full) : (w_level[0] != c_full);
  assign w_accept = in_valid & in_ready;

  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push = w_accept & (in_sel == 1'(ch));
    assign w_pop  = (r_level != '0) & w_out_ready[ch];

    // Word storage: cleared on reset, written at the write pointer on push.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[i] <= '0;
        end
      end else if (w_push) begin
        r_mem[r_wptr] <= in_data;
      end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks net push/pop.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
      end
    end

    assign w_head[ch]  = r_mem[r_rptr];
    assign w_level[ch] = r_level;
  end

  assign a_data  = w_head[0];
  assign a_level = w_level[0];
  assign a_valid = (w_level[0] != '0);
  assign b_data  = w_head[1];
  assign b_level = w_level[1];
  assign b_valid = (w_level[1] != '0);

endmodule
`default_nettype wire

// File: tb/tb_demux_1_2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_2_stream
// Description : Self-checking bench for demux_1_2_stream: directed vector
//               table, queue-based reference model under random traffic,
//               wrap-around and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_2_stream;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready = 1'b0;
  logic [LW-1:0]    a_level;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready = 1'b0;
  logic [LW-1:0]    b_level;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per output, head at index 0.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] dut_log_b[$];

  typedef struct {
    int v; int s; int d; int ar; int br;
    int rdy; int av; int ad; int al; int bv; int bd; int bl;
  } vec_t;
  vec_t tbl[19];

  demux_1_2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_level(a_level),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .b_level(b_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One model-checked cycle: drive at negedge, compare pre-edge outputs, then
  // advance the model by the same edge.
  task automatic cycle(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d,
                       input bit ar, input bit br, output bit acc);
    bit exp_rdy, pa, pb;
    @(negedge clk);
    rst = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    exp_rdy = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("a_valid", int'(a_valid), int'(qa.size() != 0));
    chk("a_level", int'(a_level), qa.size());
    chk("b_valid", int'(b_valid), int'(qb.size() != 0));
    chk("b_level", int'(b_level), qb.size());
    if (qa.size() != 0) chk("a_data", int'(a_data), int'(qa[0]));
    if (qb.size() != 0) chk("b_data", int'(b_data), int'(qb[0]));
    acc = 1'b0;
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      acc = v & exp_rdy;
      pa  = (qa.size() != 0) && ar;
      pb  = (qb.size() != 0) && br;
      if (pa) void'(qa.pop_front());
      if (pb) begin
        dut_log_b.push_back(b_data);
        void'(qb.pop_front());
      end
      if (acc) begin
        if (s) qb.push_back(d);
        else   qa.push_back(d);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    bit acc;
    int tries;
    //            v  s  d    ar br  rdy av ad   al  bv bd bl
    tbl[0]  = '{1, 0, 1,   1, 1,  1,  0, 0,   0,  0, 0, 0};
    tbl[1]  = '{1, 1, 2,   1, 1,  1,  1, 1,   1,  0, 0, 0};
    tbl[2]  = '{1, 0, 3,   1, 1,  1,  0, 0,   0,  1, 2, 1};
    tbl[3]  = '{1, 1, 4,   1, 1,  1,  1, 3,   1,  0, 0, 0};
    tbl[4]  = '{0, 0, 0,   1, 1,  1,  0, 0,   0,  1, 4, 1};
    tbl[5]  = '{1, 0, 'hA, 0, 0,  1,  0, 0,   0,  0, 0, 0};
    tbl[6]  = '{1, 0, 'hB, 0, 0,  1,  1, 'hA, 1,  0, 0, 0};
    tbl[7]  = '{0, 1, 0,   0, 0,  1,  1, 'hA, 2,  0, 0, 0};
    tbl[8]  = '{1, 0, 'hC, 0, 0,  0,  1, 'hA, 2,  0, 0, 0};
    tbl[9]  = '{1, 0, 'hC, 1, 0,  0,  1, 'hA, 2,  0, 0, 0};
    tbl[10] = '{1, 0, 'hC, 0, 0,  1,  1, 'hB, 1,  0, 0, 0};
    tbl[11] = '{0, 0, 0,   1, 0,  0,  1, 'hB, 2,  0, 0, 0};
    tbl[12] = '{0, 0, 0,   1, 0,  1,  1, 'hC, 1,  0, 0, 0};
    tbl[13] = '{0, 0, 0,   0, 0,  1,  0, 0,   0,  0, 0, 0};
    tbl[14] = '{1, 1, 5,   0, 0,  1,  0, 0,   0,  0, 0, 0};
    tbl[15] = '{1, 1, 6,   0, 1,  1,  0, 0,   0,  1, 5, 1};
    tbl[16] = '{1, 1, 7,   0, 1,  1,  0, 0,   0,  1, 6, 1};
    tbl[17] = '{0, 1, 0,   0, 1,  1,  0, 0,   0,  1, 7, 1};
    tbl[18] = '{0, 1, 0,   0, 1,  1,  0, 0,   0,  0, 0, 0};

    // Reset and idle state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0;
    #1;
    chk("rst_a_valid", int'(a_valid), 0);
    chk("rst_b_valid", int'(b_valid), 0);
    chk("rst_a_level", int'(a_level), 0);
    chk("rst_b_level", int'(b_level), 0);
    chk("rst_a_data", int'(a_data), 0);
    chk("rst_b_data", int'(b_data), 0);
    chk("rst_ready_sel0", int'(in_ready), 1);
    in_sel = 1'b1;
    #1;
    chk("rst_ready_sel1", int'(in_ready), 1);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid = 1'(tbl[i].v); in_sel = 1'(tbl[i].s); in_data = WIDTH'(tbl[i].d);
      a_ready = 1'(tbl[i].ar); b_ready = 1'(tbl[i].br);
      #1;
      chk("tbl_in_ready", int'(in_ready), tbl[i].rdy);
      chk("tbl_a_valid", int'(a_valid), tbl[i].av);
      chk("tbl_a_level", int'(a_level), tbl[i].al);
      chk("tbl_b_valid", int'(b_valid), tbl[i].bv);
      chk("tbl_b_level", int'(b_level), tbl[i].bl);
      if (tbl[i].av != 0) chk("tbl_a_data", int'(a_data), tbl[i].ad);
      if (tbl[i].bv != 0) chk("tbl_b_data", int'(b_data), tbl[i].bd);
      @(posedge clk);
    end

    // Random traffic against the queue model (both FIFOs empty here)
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom % 200) == 0, ($urandom % 4) != 0, 1'($urandom), WIDTH'($urandom),
            ($urandom % 10) < 7, ($urandom % 10) < 6, acc);
    end

    // Drain, then push ten words through B with a stuttering consumer
    repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
    dut_log_b.delete();
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 50) begin
        cycle(1'b0, 1'b1, 1'b1, WIDTH'(i), 1'b1, 1'($urandom), acc);
        tries++;
      end
      if (!acc) chk("wrap_accept_timeout", i, -1);
    end
    repeat (5) cycle(1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b1, acc);
    chk("wrap_count", dut_log_b.size(), 10);
    for (int i = 0; i < 10 && i < dut_log_b.size(); i++) begin
      chk("wrap_order", int'(dut_log_b[i]), i);
    end

    // Reset mid-operation with a word offered
    cycle(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 1'b0, 4'h5, 1'b1, 1'b1, acc);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    #1;
    chk("mrst_a_level", int'(a_level), 0);
    chk("mrst_b_level", int'(b_level), 0);
    chk("mrst_a_valid", int'(a_valid), 0);
    chk("mrst_b_valid", int'(b_valid), 0);
    chk("mrst_a_data", int'(a_data), 0);
    chk("mrst_b_data", int'(b_data), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1_2_stream.md
# demux_1_2_stream

Stream demultiplexer, the receive-side counterpart of the 2:1 word mux: accepts one tagged WIDTH-bit word stream and steers each word to output port A or B according to its select tag. Each output owns a DEPTH-entry first-word-fall-through FIFO with valid/ready handshaking, so a stalled consumer on one side does not lose data. It sits between a shared datapath and two independent consumers.

## Interface
- WIDTH, 4, data word width in bits
- DEPTH, 2, entries per output FIFO; power of two, >= 2
- LW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  WIDTH  incoming word
- in_sel  input  1  0 = route to A, 1 = route to B
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts the word this cycle
- a_data  output  WIDTH  head word of FIFO A
- a_valid  output  1  FIFO A non-empty
- a_ready  input  1  consumer A takes head this cycle
- a_level  output  LW  FIFO A occupancy, 0..DEPTH
- b_data, b_valid, b_ready, b_level: same as A for FIFO B

Clock is one domain (clk); reset is synchronous and active-high (rst).

## Operation
- Accept = in_valid & in_ready. in_ready = in_sel ? (b_level != DEPTH) : (a_level != DEPTH); combinational from in_sel and registered levels only, never from a_ready/b_ready.
- On accept, in_data is written at the selected FIFO's write pointer; the other FIFO is untouched.
- Pop X = X_valid & X_ready. Pop with X_valid=0 is ignored.
- X_valid = (X_level != 0); X_data = memory[read pointer], registered storage, combinational read.
- Per FIFO: push only -> level+1; pop only -> level-1; push and pop same cycle -> level unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Full FIFO: in_ready=0 for words tagged to it even if that FIFO pops in the same cycle (no pass-through); the word waits at the input. Words for the other FIFO are unaffected only when they arrive at the head; the input is strictly in order, so a blocked head stalls the whole input stream (no reordering).
- Per-output order equals input order of words with that tag.
- Word in FIFO is never overwritten or dropped; in_data change while in_valid & !in_ready is legal and simply means the upstream changed its offer.
- rst: pointers, levels and all storage cleared to 0 in the cycle rst is sampled high, regardless of operations in flight; accepts/pops in that cycle are discarded.

## Timing
- Reset values: a_valid=b_valid=0, a_level=b_level=0, a_data=b_data=0, in_ready=1 (both FIFOs empty).
- Latency: word accepted on edge N is visible at X_data with X_valid=1 after edge N (cycle N+1); no same-cycle bypass from input to output.
- Pop on edge N: next word (or X_valid=0) visible after edge N.
- Throughput: one accept and one pop per FIFO per cycle sustained once non-empty and non-full.
- in_ready deasserts the cycle after the push that makes the selected FIFO full, and reasserts the cycle after the pop that frees a slot.

## Test plan
- Reset then idle: after rst, a_valid=b_valid=0, levels=0, data=0, in_ready=1 for in_sel=0 and 1.
- Alternate routing: send 0x1(sel0),0x2(sel1),0x3(sel0),0x4(sel1), both readys high -> A emits 0x1,0x3, B emits 0x2,0x4, each one cycle after accept.
- Fill A with b_ready don't-care, a_ready=0, DEPTH=2: push 0xA,0xB -> a_level=2, in_ready=0 for sel=0, in_ready=1 for sel=1; a third sel0 word 0xC waits, then a_ready=1 one cycle -> 0xA popped, 0xC accepted next cycle, output order 0xA,0xB,0xC.
- Simultaneous push/pop at level 1 on B: level stays 1, B outputs in order; wrap test with 10 sequential words through B with DEPTH=2 -> all 10 out in order, no loss.
- Reset mid-operation: A level 2, B level 1, assert rst for one cycle with in_valid=1 -> all levels 0, valids 0, input word not captured.
